// File: rtl/ltc2308_pkg.sv
// rtl/ltc2308_pkg.sv - shared constants, state encoding and config-word builder for the LTC2308 scanner
//
// Purpose: widths of the ADC result and config word, bit positions of the
// LTC2308 6-bit DIN word, the scanner FSM state type and cfg_word(ch).
// Ports: none (package).
package ltc2308_pkg;

  localparam int DATA_W = 12;
  localparam int CFG_W  = 6;

  // Bit positions inside the 6-bit DIN word, shifted MSB first.
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_SHIFT,
    ST_STORE
  } state_t;

  // Single-ended, unipolar, no sleep. The channel bits are not in binary
  // order on the pins: O/S carries ch[0], S1 carries ch[2], S0 carries ch[1].
  function automatic logic [CFG_W-1:0] cfg_word(input logic [2:0] ch);
    logic [CFG_W-1:0] w;
    w          = '0;
    w[CFG_SD]  = 1'b1;
    w[CFG_OS]  = ch[0];
    w[CFG_S1]  = ch[2];
    w[CFG_S0]  = ch[1];
    w[CFG_UNI] = 1'b1;
    w[CFG_SLP] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/ltc2308_frame.sv
// rtl/ltc2308_frame.sv - one 12-bit SCK/shift frame toward the LTC2308
//
// Purpose: on go, runs 24 SCK half-periods of CLK_DIV cycles each. Shifts the
// 6-bit config out on mosi (then zeros) and the 12-bit result in from miso.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   go          one-cycle pulse in the cycle before the frame's first cycle
//   cfg         config word sent during this frame
//   miso        ADC DOUT
//   sck, mosi   SPI clock (idles low) and ADC DIN, both registered
//   done        high in the last cycle of the frame
//   rx          received word; complete from the cycle after done
module ltc2308_frame
  import ltc2308_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [CFG_W-1:0]  cfg,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic              done,
  output logic [DATA_W-1:0] rx
);

  localparam int         DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [4:0] LAST_HALF = 5'd23;

  logic              active_q;
  logic [DIV_W-1:0]  div_q;
  logic [4:0]        half_q;
  logic              sck_q;
  logic              mosi_q;
  logic [CFG_W-1:0]  cfg_q;
  logic [DATA_W-1:0] rx_q;

  logic       div_end;
  logic [4:0] half_nx;

  assign div_end = (div_q == DIV_W'(CLK_DIV - 1));
  assign half_nx = half_q + 5'd1;
  assign done    = active_q && div_end && (half_q == LAST_HALF);

  assign sck  = sck_q;
  assign mosi = mosi_q;
  assign rx   = rx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      div_q    <= '0;
      half_q   <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      cfg_q    <= '0;
      rx_q     <= '0;
    end else if (go) begin
      // First bit must already be on DIN when cs falls.
      active_q <= 1'b1;
      div_q    <= '0;
      half_q   <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= cfg[CFG_W-1];
      cfg_q    <= cfg;
    end else if (active_q) begin
      // Sample DOUT during the first cycle of each high half-period.
      if (sck_q && (div_q == '0)) begin
        rx_q <= {rx_q[DATA_W-2:0], miso};
      end
      if (div_end) begin
        div_q <= '0;
        if (half_q == LAST_HALF) begin
          active_q <= 1'b0;
          sck_q    <= 1'b0;
        end else begin
          half_q <= half_nx;
          sck_q  <= half_nx[0];
          // DIN only moves on a falling edge: bits 4..0, then zeros.
          if (!half_nx[0]) begin
            mosi_q <= (half_nx < 5'd12) ? cfg_q[3'd5 - half_nx[3:1]] : 1'b0;
          end
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ltc2308_scan.sv
// rtl/ltc2308_scan.sv - multi-channel LTC2308 scanner with averaging and config-pipeline tracking
//
// Purpose: drives CONVST/SPI of the LTC2308, scans channels 0..NUM_CH-1 with
// 2^AVG_LOG2 conversions each, tags results with the channel whose config
// was loaded one frame earlier, in continuous or one-shot mode.
// Ports:
//   clk_50, reset          50 MHz clock, synchronous active-high reset
//   mode_in, start         1 = continuous; else a start pulse runs one scan
//   sck, cs, mosi, miso    ADC pins (cs is CONVST)
//   readings               latest result per channel, ch0 in [11:0]
//   sample_valid/ch/data   one-cycle strobe with a finished channel result
//   scan_done              strobe alongside the last channel's result
//   busy                   high while not idle
module ltc2308_scan
  import ltc2308_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80,
  parameter int AVG_LOG2    = 0
) (
  input  logic                     clk_50,
  input  logic                     reset,
  input  logic                     mode_in,
  input  logic                     start,
  output logic                     sck,
  output logic                     cs,
  output logic                     mosi,
  input  logic                     miso,
  output logic [NUM_CH*DATA_W-1:0] readings,
  output logic                     sample_valid,
  output logic [2:0]               sample_ch,
  output logic [DATA_W-1:0]        sample_data,
  output logic                     scan_done,
  output logic                     busy
);

  localparam int NUM_SUB = 1 << AVG_LOG2;
  localparam int M       = NUM_CH * NUM_SUB;
  localparam int K_W     = 7;
  localparam int ACC_W   = DATA_W + AVG_LOG2;
  localparam int CONV_W  = $clog2(CONV_CYCLES + 1);

  state_t                   state_q, state_d;
  logic [CONV_W-1:0]        conv_cnt_q;
  logic [K_W-1:0]           k_q;       // conversion whose DOUT the current frame carries
  logic                     prime_q;   // current frame only loads config, DOUT is junk
  logic [ACC_W-1:0]         acc_q;
  logic                     cs_q;
  logic                     busy_q;
  logic [NUM_CH*DATA_W-1:0] readings_q;
  logic                     sample_valid_q;
  logic [2:0]               sample_ch_q;
  logic [DATA_W-1:0]        sample_data_q;
  logic                     scan_done_q;

  logic              conv_end, frame_go, frame_done;
  logic              first_sub, last_sub, last_conv, scan_end;
  logic [K_W-1:0]    next_k, cfg_k;
  logic [2:0]        cur_ch, cfg_ch;
  logic [ACC_W-1:0]  acc_sum;
  logic [DATA_W-1:0] frame_rx, result;

  assign conv_end  = (conv_cnt_q == CONV_W'(CONV_CYCLES - 1));
  assign frame_go  = (state_q == ST_CONV) && conv_end;
  assign cur_ch    = 3'(k_q >> AVG_LOG2);
  assign first_sub = ((k_q & K_W'(NUM_SUB - 1)) == '0);
  assign last_sub  = ((k_q & K_W'(NUM_SUB - 1)) == K_W'(NUM_SUB - 1));
  assign last_conv = (k_q == K_W'(M - 1));
  assign next_k    = last_conv ? '0 : k_q + 1'b1;
  // DIN of a frame selects the following conversion; the priming frame and
  // the last frame of a scan both load conversion 0 (channel 0).
  assign cfg_k     = prime_q ? '0 : next_k;
  assign cfg_ch    = 3'(cfg_k >> AVG_LOG2);
  assign scan_end  = (state_q == ST_STORE) && !prime_q && last_conv;
  assign acc_sum   = (first_sub ? '0 : acc_q) + ACC_W'(frame_rx);
  assign result    = DATA_W'(acc_sum >> AVG_LOG2);

  ltc2308_frame #(
    .CLK_DIV(CLK_DIV)
  ) u_frame (
    .clk  (clk_50),
    .reset(reset),
    .go   (frame_go),
    .cfg  (cfg_word(cfg_ch)),
    .miso (miso),
    .sck  (sck),
    .mosi (mosi),
    .done (frame_done),
    .rx   (frame_rx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (mode_in || start) state_d = ST_CONV;
      ST_CONV:  if (conv_end) state_d = ST_SHIFT;
      ST_SHIFT: if (frame_done) state_d = ST_STORE;
      ST_STORE: state_d = (scan_end && !mode_in) ? ST_IDLE : ST_CONV;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      conv_cnt_q     <= '0;
      k_q            <= '0;
      prime_q        <= 1'b1;
      acc_q          <= '0;
      cs_q           <= 1'b1;
      busy_q         <= 1'b0;
      readings_q     <= '0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      sample_data_q  <= '0;
      scan_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cs_q           <= (state_d != ST_SHIFT);
      busy_q         <= (state_d != ST_IDLE);
      sample_valid_q <= 1'b0;
      scan_done_q    <= 1'b0;
      conv_cnt_q     <= ((state_q == ST_CONV) && !conv_end) ? conv_cnt_q + 1'b1 : '0;
      if (state_q == ST_STORE) begin
        if (prime_q) begin
          prime_q <= 1'b0;
        end else begin
          acc_q <= acc_sum;
          k_q   <= next_k;
          if (last_sub) begin
            readings_q[int'(cur_ch)*DATA_W +: DATA_W] <= result;
            sample_valid_q <= 1'b1;
            sample_ch_q    <= cur_ch;
            sample_data_q  <= result;
            scan_done_q    <= last_conv;
          end
        end
        // A scan restarted from IDLE finds the ADC config stale again.
        if (state_d == ST_IDLE) begin
          prime_q <= 1'b1;
        end
      end
    end
  end

  assign cs           = cs_q;
  assign busy         = busy_q;
  assign readings     = readings_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign sample_data  = sample_data_q;
  assign scan_done    = scan_done_q;

endmodule

// File: tb/tb_ltc2308_scan.sv
// tb/tb_ltc2308_scan.sv - testbench for ltc2308_scan with an LTC2308 pin model
module tb_ltc2308_scan;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] data;
    logic        done;
    int          gap;
  } smp_t;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] bits;
  } cfg_t;

  logic        clk = 1'b0;
  logic [2:0]  rst, mode, start;
  logic        sck [3];
  logic        cs [3];
  logic        mosi [3];
  logic        miso [3];
  logic        sv [3];
  logic [2:0]  sch [3];
  logic [11:0] sdat [3];
  logic        sdone [3];
  logic        busy [3];
  logic [35:0] rd0, rd1;
  logic [95:0] rd2;

  int   n_chk = 0;
  int   n_err = 0;
  bit   fff_seen = 1'b0;
  smp_t smp_tab [6];
  cfg_t cfg_tab [8];

  always #10 clk = ~clk;

  ltc2308_scan #(.NUM_CH(3), .CLK_DIV(2), .CONV_CYCLES(80), .AVG_LOG2(0)) u_dut0 (
    .clk_50(clk), .reset(rst[0]), .mode_in(mode[0]), .start(start[0]),
    .sck(sck[0]), .cs(cs[0]), .mosi(mosi[0]), .miso(miso[0]), .readings(rd0),
    .sample_valid(sv[0]), .sample_ch(sch[0]), .sample_data(sdat[0]),
    .scan_done(sdone[0]), .busy(busy[0]));

  ltc2308_scan #(.NUM_CH(3), .CLK_DIV(2), .CONV_CYCLES(80), .AVG_LOG2(2)) u_dut1 (
    .clk_50(clk), .reset(rst[1]), .mode_in(mode[1]), .start(start[1]),
    .sck(sck[1]), .cs(cs[1]), .mosi(mosi[1]), .miso(miso[1]), .readings(rd1),
    .sample_valid(sv[1]), .sample_ch(sch[1]), .sample_data(sdat[1]),
    .scan_done(sdone[1]), .busy(busy[1]));

  ltc2308_scan #(.NUM_CH(8), .CLK_DIV(2), .CONV_CYCLES(80), .AVG_LOG2(0)) u_dut2 (
    .clk_50(clk), .reset(rst[2]), .mode_in(mode[2]), .start(start[2]),
    .sck(sck[2]), .cs(cs[2]), .mosi(mosi[2]), .miso(miso[2]), .readings(rd2),
    .sample_valid(sv[2]), .sample_ch(sch[2]), .sample_data(sdat[2]),
    .scan_done(sdone[2]), .busy(busy[2]));

  assign miso[2] = 1'b0;

  // ADC model: DIN captured on SCK rise, DOUT advanced on SCK fall. A frame
  // returns data for the channel configured by the previous complete frame,
  // 12'hFFF if there is none. Instance 1 adds 0x10*ch and a 0..3 sub-index.
  for (genvar g = 0; g < 2; g++) begin : g_adc
    logic [5:0]  din_q;
    logic [5:0]  pend;
    logic [11:0] word;
    logic [2:0]  ch;
    logic [1:0]  subc [8];
    bit          pend_ok;
    int          rises;
    int          falls;

    initial begin
      din_q = '0; pend = '0; word = 12'hFFF; ch = '0;
      pend_ok = 1'b0; rises = 0; falls = 12;
      for (int i = 0; i < 8; i++) subc[i] = '0;
    end

    always @(posedge sck[g]) begin
      if (rises < 6) din_q = {din_q[4:0], mosi[g]};
      rises++;
    end

    always @(negedge sck[g]) falls++;

    always @(posedge cs[g]) begin
      pend_ok = (rises == 12);
      pend    = din_q;
    end

    always @(negedge cs[g]) begin
      rises = 0;
      falls = 0;
      if (!pend_ok) begin
        word = 12'hFFF;
      end else begin
        ch = {pend[3], pend[2], pend[4]};
        if (g == 1) begin
          word = 12'h100 + {5'b0, ch, 4'h0} + {10'b0, subc[ch]};
          subc[ch] = subc[ch] + 2'd1;
        end else begin
          word = 12'h100 + {9'b0, ch};
        end
      end
    end

    assign miso[g] = (falls < 12) ? word[11 - falls] : 1'b0;
  end

  always @(negedge clk) begin
    if (sv[0] === 1'b1 && sdat[0] == 12'hFFF) fff_seen = 1'b1;
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_oneshot(input int g, input int r0, input int n, input bit poke);
    int cyc;
    @(negedge clk);
    start[g] = 1'b1;
    for (int r = r0; r < r0 + n; r++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        start[g] = poke && (r == r0) && (cyc == 100);
      end while (!sv[g] && cyc < 2000);
      chk($sformatf("dut%0d_row%0d_gap", g, r), cyc, smp_tab[r].gap);
      chk($sformatf("dut%0d_row%0d_ch", g, r), sch[g], smp_tab[r].ch);
      chk($sformatf("dut%0d_row%0d_data", g, r), sdat[g], smp_tab[r].data);
      chk($sformatf("dut%0d_row%0d_done", g, r), sdone[g], smp_tab[r].done);
    end
  endtask

  task automatic wait_done(input int g, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!sdone[g] && cyc < 2000);
  endtask

  task automatic quiet(input int g, input int ncyc, input string nm);
    int nsv, nbusy;
    nsv = 0;
    nbusy = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (sv[g]) nsv++;
      if (busy[g]) nbusy++;
    end
    chk({nm, "_no_samples"}, nsv, 0);
    chk({nm, "_not_busy"}, nbusy, 0);
  endtask

  initial begin
    int         cyc;
    int         w;
    logic [11:0] bits;

    smp_tab[0] = '{3'd0, 12'h100, 1'b0, 259};
    smp_tab[1] = '{3'd1, 12'h101, 1'b0, 129};
    smp_tab[2] = '{3'd2, 12'h102, 1'b1, 129};
    smp_tab[3] = '{3'd0, 12'h101, 1'b0, 646};
    smp_tab[4] = '{3'd1, 12'h111, 1'b0, 516};
    smp_tab[5] = '{3'd2, 12'h121, 1'b1, 516};
    cfg_tab[0] = '{3'd0, {6'b100010, 6'b0}};
    cfg_tab[1] = '{3'd1, {6'b110010, 6'b0}};
    cfg_tab[2] = '{3'd2, {6'b100110, 6'b0}};
    cfg_tab[3] = '{3'd3, {6'b110110, 6'b0}};
    cfg_tab[4] = '{3'd4, {6'b101010, 6'b0}};
    cfg_tab[5] = '{3'd5, {6'b111010, 6'b0}};
    cfg_tab[6] = '{3'd6, {6'b101110, 6'b0}};
    cfg_tab[7] = '{3'd7, {6'b111110, 6'b0}};

    rst = 3'b111;
    mode = 3'b000;
    start = 3'b000;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst%0d_sck", g), sck[g], 1'b0);
      chk($sformatf("rst%0d_cs", g), cs[g], 1'b1);
      chk($sformatf("rst%0d_mosi", g), mosi[g], 1'b0);
      chk($sformatf("rst%0d_valid", g), sv[g], 1'b0);
      chk($sformatf("rst%0d_ch", g), sch[g], 3'd0);
      chk($sformatf("rst%0d_data", g), sdat[g], 12'h0);
      chk($sformatf("rst%0d_done", g), sdone[g], 1'b0);
      chk($sformatf("rst%0d_busy", g), busy[g], 1'b0);
    end
    chk("rst0_readings", rd0, 36'h0);
    chk("rst1_readings", rd1, 36'h0);
    chk("rst2_readings", rd2, 96'h0);
    rst = 3'b000;

    // One-shot scan with a start pulse poked mid-scan.
    run_oneshot(0, 0, 3, 1'b1);
    chk("oneshot_readings", rd0, {12'h102, 12'h101, 12'h100});
    quiet(0, 300, "oneshot_idle");

    // Continuous: two full scans, then mode drops mid third scan.
    @(negedge clk);
    mode[0] = 1'b1;
    wait_done(0, cyc);
    chk("cont_first_done", cyc, 517);
    wait_done(0, cyc);
    chk("cont_scan_period", cyc, 387);
    mode[0] = 1'b0;
    wait_done(0, cyc);
    chk("cont_last_scan_period", cyc, 387);
    quiet(0, 300, "cont_stop");

    // Reset while shifting.
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    w = 0;
    while (cs[0] !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    repeat (10) @(negedge clk);
    chk("mid_shift_sck_high", sck[0], 1'b1);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("rstmid_cs", cs[0], 1'b1);
    chk("rstmid_sck", sck[0], 1'b0);
    chk("rstmid_mosi", mosi[0], 1'b0);
    chk("rstmid_busy", busy[0], 1'b0);
    chk("rstmid_valid", sv[0], 1'b0);
    chk("rstmid_readings", rd0, 36'h0);
    rst[0] = 1'b0;
    run_oneshot(0, 0, 3, 1'b0);
    chk("refill_readings", rd0, {12'h102, 12'h101, 12'h100});

    // Averaging over four conversions per channel.
    run_oneshot(1, 3, 3, 1'b0);
    chk("avg_readings", rd1, {12'h121, 12'h111, 12'h101});

    // Eight channels: DIN of every frame including priming and wrap-around.
    @(negedge clk);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    for (int f = 0; f < 9; f++) begin
      bits = '0;
      for (int b = 0; b < 12; b++) begin
        w = 0;
        while (sck[2] !== 1'b1 && w < 300) begin
          @(negedge clk);
          w++;
        end
        bits = {bits[10:0], mosi[2]};
        w = 0;
        while (sck[2] !== 1'b0 && w < 300) begin
          @(negedge clk);
          w++;
        end
      end
      chk($sformatf("cfg_frame%0d_ch%0d", f, cfg_tab[f % 8].ch), bits, cfg_tab[f % 8].bits);
    end
    wait_done(2, cyc);
    chk("ch8_scan_done_ch", sch[2], 3'd7);

    chk("no_fff_stored", fff_seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
